// File: rtl/fma_sum_stage.sv
// fma_sum_stage: two-stage compound adder for the FMA datapath.
// Stage 1 forms sum0 = prod + zin and sum1 = sum0 + 1 and exposes their
// sign bits to the external sign logic. Stage 2 applies the returned
// selsum1/negsum decisions and produces the result magnitude and zero flag.
module fma_sum_stage #(
  parameter int W = 164
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] prod,
  input  logic [W-1:0] addend,
  input  logic         invz,
  output logic         s1_valid,
  output logic         s1_invz,
  output logic         negsum0,
  output logic         negsum1,
  input  logic         selsum1,
  input  logic         negsum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         sumzero
);

  // Two's-complement negation when requested. Only the low W bits of the
  // W+1-bit negation reach the output, and those depend only on the low W
  // bits of the operand, so the operand is taken at W bits.
  function automatic logic [W-1:0] f_cond_negate(input logic [W-1:0] v,
                                                 input logic         neg);
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    return neg ? (~v + one) : v;
  endfunction

  logic         r_vld_p1;
  logic         r_invz_p1;
  logic [W:0]   r_sum0_p1;
  logic [W:0]   r_sum1_p1;
  logic         r_vld_p2;
  logic [W-1:0] r_sum_p2;
  logic         r_zero_p2;

  logic [W:0]   w_prod_p0;
  logic [W:0]   w_zin_p0;
  logic [W:0]   w_sum0_p0;
  logic [W:0]   w_sum1_p0;
  logic [W-1:0] w_sel_p1;
  logic [W-1:0] w_res_p1;
  logic         w_accept;
  logic         w_advance;
  logic         w_drain;

  // ---- stage 0: operand extension and compound add ----
  assign w_prod_p0 = {1'b0, prod};
  assign w_zin_p0  = invz ? ~{1'b0, addend} : {1'b0, addend};
  assign w_sum0_p0 = w_prod_p0 + w_zin_p0;
  assign w_sum1_p0 = w_sum0_p0 + {{W{1'b0}}, 1'b1};

  // ---- flow control ----
  assign w_advance = r_vld_p1 && (!r_vld_p2 || out_ready);
  assign in_ready  = !r_vld_p1 || w_advance;
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = r_vld_p2 && out_ready;

  // Stage-1 occupancy; flush kills the operation, reset overrides flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
    end else if (w_advance) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Stage-1 data; cleared on reset so the sign flags start at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_invz_p1 <= 1'b0;
      r_sum0_p1 <= '0;
      r_sum1_p1 <= '0;
    end else if (w_accept) begin
      r_invz_p1 <= invz;
      r_sum0_p1 <= w_sum0_p0;
      r_sum1_p1 <= w_sum1_p0;
    end
  end

  // ---- stage 1: apply sign-logic decisions ----
  assign w_sel_p1 = selsum1 ? r_sum1_p1[W-1:0] : r_sum0_p1[W-1:0];
  assign w_res_p1 = f_cond_negate(w_sel_p1, negsum);

  // Result occupancy: loaded on advance, emptied by a handshake without reload.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_vld_p2 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p2 <= 1'b1;
    end else if (w_drain) begin
      r_vld_p2 <= 1'b0;
    end
  end

  // Result data; held while stalled, zeroed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_p2  <= '0;
      r_zero_p2 <= 1'b0;
    end else if (w_advance) begin
      r_sum_p2  <= w_res_p1;
      r_zero_p2 <= (w_res_p1 == '0);
    end
  end

  // ---- stage 2: outputs ----
  assign s1_valid  = r_vld_p1;
  assign s1_invz   = r_invz_p1;
  assign negsum0   = r_sum0_p1[W];
  assign negsum1   = r_sum1_p1[W];
  assign out_valid = r_vld_p2;
  assign sum       = r_sum_p2;
  assign sumzero   = r_zero_p2;

endmodule

// File: tb/tb_fma_sum_stage.sv
// Directed bench for fma_sum_stage at W=8.
module tb_fma_sum_stage;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [W-1:0] prod, addend;
  logic         invz, s1_valid, s1_invz, negsum0, negsum1;
  logic         selsum1, negsum, out_valid, out_ready;
  logic [W-1:0] sum;
  logic         sumzero;

  int n_total = 0;
  int n_pass  = 0;

  fma_sum_stage #(.W(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .addend(addend), .invz(invz),
    .s1_valid(s1_valid), .s1_invz(s1_invz),
    .negsum0(negsum0), .negsum1(negsum1),
    .selsum1(selsum1), .negsum(negsum),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sumzero(sumzero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] p;
    logic [7:0] a;
    logic       iz;
    logic       s1;
    logic       ng;
    logic       e_n0;
    logic       e_n1;
    logic [7:0] e_sum;
    logic       e_zero;
  } vec_t;

  vec_t vt[8];

  logic [7:0] exp_q[4];
  logic [7:0] held_sum;
  int         accepts, nout, seen;
  logic       held, will_out, will_acc;

  initial begin
    // p, a, invz, selsum1, negsum, negsum0, negsum1, sum, sumzero
    vt[0] = '{8'h30, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0};
    vt[1] = '{8'h10, 8'h30, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0};
    vt[2] = '{8'h25, 8'h25, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[3] = '{8'h25, 8'h25, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[6] = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0};
    vt[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; prod = '0; addend = '0;
    invz = 1'b0; selsum1 = 1'b0; negsum = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_s1_valid", s1_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s1_invz", s1_invz, 0);
    chk("rst_negsum0", negsum0, 0);
    chk("rst_negsum1", negsum1, 0);
    chk("rst_sum", sum, 0);
    chk("rst_sumzero", sumzero, 0);
    chk("rst_in_ready", in_ready, 1);

    // Table-driven single operations, no back-pressure.
    for (int i = 0; i < 8; i++) begin
      prod = vt[i].p; addend = vt[i].a; invz = vt[i].iz; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_s1_valid", i), s1_valid, 1);
      chk($sformatf("v%0d_s1_invz", i), s1_invz, vt[i].iz);
      chk($sformatf("v%0d_negsum0", i), negsum0, vt[i].e_n0);
      chk($sformatf("v%0d_negsum1", i), negsum1, vt[i].e_n1);
      chk($sformatf("v%0d_out_valid_early", i), out_valid, 0);
      selsum1 = vt[i].s1; negsum = vt[i].ng;
      tick();
      selsum1 = 1'b0; negsum = 1'b0;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_s1_empty", i), s1_valid, 0);
      chk($sformatf("v%0d_sum", i), sum, vt[i].e_sum);
      chk($sformatf("v%0d_sumzero", i), sumzero, vt[i].e_zero);
      tick();
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Back-pressure: 4 additions, out_ready low for cycles 1..3.
    for (int k = 0; k < 4; k++) exp_q[k] = 8'((k + 1) * 8'h12);
    accepts = 0; nout = 0; held = 1'b0; held_sum = '0;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (accepts < 4);
      prod      = 8'((accepts + 1) * 8'h11);
      addend    = 8'(accepts + 1);
      invz      = 1'b0;
      #0;
      if (held) chk("bp_sum_stable", sum, held_sum);
      if (s1_valid && out_valid && !out_ready) chk("bp_in_ready_low", in_ready, 0);
      if (cyc == 2) chk("bp_accepts_before_full", accepts, 2);
      will_out = out_valid && out_ready;
      will_acc = in_valid && in_ready;
      if (will_out) begin
        chk($sformatf("bp_out%0d", nout), sum, exp_q[nout]);
        nout++;
      end
      held = out_valid && !out_ready;
      held_sum = sum;
      tick();
      if (will_acc) accepts++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_results_count", nout, 4);
    chk("bp_no_duplicate", out_valid, 0);
    tick();

    // Flush while both stages are valid, together with an accept.
    out_ready = 1'b0;
    in_valid = 1'b1; prod = 8'h01; addend = 8'h01; tick();
    prod = 8'h02; addend = 8'h02; tick();
    chk("fl_full_s1", s1_valid, 1);
    chk("fl_full_out", out_valid, 1);
    out_ready = 1'b1; prod = 8'h03; addend = 8'h03; flush = 1'b1;
    #0;
    chk("fl_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_s1_valid", s1_valid, 0);
    chk("fl_out_valid", out_valid, 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("fl_nothing_emerges", seen, 0);
    in_valid = 1'b1; prod = 8'h05; addend = 8'h06; tick();
    in_valid = 1'b0; tick();
    chk("fl_fresh_valid", out_valid, 1);
    chk("fl_fresh_sum", sum, 8'h0B);
    tick();

    // Reset mid-stream with flush also asserted.
    out_ready = 1'b0;
    in_valid = 1'b1; prod = 8'h10; addend = 8'h30; invz = 1'b1; tick();
    prod = 8'hFF; addend = 8'h01; invz = 1'b0; tick();
    chk("rs_full", s1_valid && out_valid, 1);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; invz = 1'b0;
    chk("rs_s1_valid", s1_valid, 0);
    chk("rs_out_valid", out_valid, 0);
    chk("rs_s1_invz", s1_invz, 0);
    chk("rs_negsum0", negsum0, 0);
    chk("rs_negsum1", negsum1, 0);
    chk("rs_sum", sum, 0);
    chk("rs_sumzero", sumzero, 0);
    chk("rs_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
